// File: rtl/btn_debounce_if.sv
// Signal bundle between a raw button source and the debouncer.
// The source drives i_btn; the debouncer returns the clean level and edge pulses.
interface btn_debounce_if;
  logic i_btn;
  logic o_level;
  logic o_rise;
  logic o_fall;

  modport master (output i_btn, input o_level, o_rise, o_fall);
  modport slave  (input i_btn, output o_level, o_rise, o_fall);
endinterface

// File: rtl/btn_debounce.sv
// Button debouncer: 2-FF synchroniser, 4-state debounce FSM, registered level/edge outputs.
// A change is accepted only after the synchronised input has held it for DEBOUNCE_CYCLES+1 edges.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 20
) (
  input  logic       i_clk,
  input  logic       i_rst,
  btn_debounce_if.slave bus
);

  typedef enum logic [1:0] {
    ST_LOW   = 2'd0,
    ST_WAITH = 2'd1,
    ST_HIGH  = 2'd2,
    ST_WAITL = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_DONE = CNT_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 s1, s2;
  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 level_q, level_d;
  logic                 rise_q, rise_d;
  logic                 fall_q, fall_d;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse s1/s2 into a single stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= bus.i_btn;
      s2 <= s1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    unique case (state_q)
      ST_LOW: begin
        level_d = 1'b0;
        if (s2) begin
          state_d = ST_WAITH;
          cnt_d   = CNT_ONE;
        end
      end

      ST_WAITH: begin
        if (!s2) begin
          state_d = ST_LOW;
        end else if (cnt_q == CNT_DONE) begin
          state_d = ST_HIGH;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_HIGH: begin
        level_d = 1'b1;
        if (!s2) begin
          state_d = ST_WAITL;
          cnt_d   = CNT_ONE;
        end
      end

      ST_WAITL: begin
        if (s2) begin
          state_d = ST_HIGH;
        end else if (cnt_q == CNT_DONE) begin
          state_d = ST_LOW;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_LOW;
        level_d = 1'b0;
      end
    endcase
  end

  assign bus.o_level = level_q;
  assign bus.o_rise  = rise_q;
  assign bus.o_fall  = fall_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce (DEBOUNCE_CYCLES=4): directed scenarios plus
// randomized runs compared against a run-length reference model.
module tb_btn_debounce;

  localparam int D = 4;

  logic i_clk;
  logic i_rst;
  int   tests;
  int   fails;

  btn_debounce_if bus ();

  btn_debounce #(.DEBOUNCE_CYCLES(D), .CNT_WIDTH(3)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model: the synchroniser is a 2-edge delay; a change is accepted
  // once the delayed input has differed from the level for D+1 consecutive edges.
  logic m_s1, m_s2, m_lvl, m_rise, m_fall;
  int   m_run;

  task automatic model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_lvl = 1'b0; m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
  endtask

  // Advance one clock edge, update the model, and return 1 ns after the edge.
  task automatic tick();
    logic seen;
    @(posedge i_clk);
    m_rise = 1'b0;
    m_fall = 1'b0;
    if (i_rst) begin
      model_reset();
    end else begin
      seen = m_s2;
      if (seen != m_lvl) begin
        m_run++;
        if (m_run == D + 1) begin
          m_lvl  = seen;
          m_rise = seen;
          m_fall = !seen;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = bus.i_btn;
    end
    #1;
  endtask

  task automatic settle(input logic v, input int n);
    bus.i_btn = v;
    repeat (n) tick();
  endtask

  function automatic logic [2:0] outs();
    return {bus.o_level, bus.o_rise, bus.o_fall};
  endfunction

  task automatic test_reset();
    logic [2:0] exp;
    i_rst = 1'b1;
    bus.i_btn = 1'b1;
    model_reset();
    #1;
    tests++;
    if (outs() !== 3'b000) begin
      fails++;
      $display("FAIL reset_async: got {lvl,rise,fall}=%b expected 000", outs());
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      tests++;
      if (outs() !== 3'b000) begin
        fails++;
        $display("FAIL reset_hold edge %0d: got %b expected 000", k, outs());
      end
    end
    i_rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp = {k >= 7, k == 7, 1'b0};
      tests++;
      if (outs() !== exp) begin
        fails++;
        $display("FAIL reset_release edge %0d: got %b expected %b", k, outs(), exp);
      end
    end
  endtask

  task automatic test_release();
    logic [2:0] exp;
    settle(1'b1, 4);
    bus.i_btn = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp = {k < 7, 1'b0, k == 7};
      tests++;
      if (outs() !== exp) begin
        fails++;
        $display("FAIL release edge %0d: got %b expected %b", k, outs(), exp);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [2:0] exp;
    settle(1'b0, 4);
    bus.i_btn = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp = {k >= 7, k == 7, 1'b0};
      tests++;
      if (outs() !== exp) begin
        fails++;
        $display("FAIL clean_press edge %0d: got %b expected %b", k, outs(), exp);
      end
    end
    settle(1'b1, 3);
  endtask

  // Pulses of D-1 and D cycles must be rejected; D+1 is the shortest accepted.
  task automatic test_glitch();
    int rises;
    for (int w = D - 1; w <= D + 1; w++) begin
      settle(1'b0, 12);
      rises = 0;
      bus.i_btn = 1'b1;
      repeat (w) begin tick(); rises += bus.o_rise; end
      bus.i_btn = 1'b0;
      repeat (12) begin tick(); rises += bus.o_rise; end
      tests++;
      if (rises !== ((w > D) ? 1 : 0)) begin
        fails++;
        $display("FAIL glitch width %0d: got %0d rises expected %0d", w, rises, (w > D) ? 1 : 0);
      end
    end
    settle(1'b0, 12);
    tests++;
    if (outs() !== 3'b000) begin
      fails++;
      $display("FAIL glitch_settle: got %b expected 000", outs());
    end
  endtask

  task automatic test_bounce();
    logic [2:0] exp;
    int rises;
    rises = 0;
    settle(1'b0, 10);
    for (int b = 0; b < 4; b++) begin
      bus.i_btn = (b % 2 == 0);
      repeat (2) begin tick(); rises += bus.o_rise; end
    end
    bus.i_btn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      rises += bus.o_rise;
      exp = {k >= 7, k == 7, 1'b0};
      tests++;
      if (outs() !== exp) begin
        fails++;
        $display("FAIL bounce edge %0d: got %b expected %b", k, outs(), exp);
      end
    end
    tests++;
    if (rises !== 1) begin
      fails++;
      $display("FAIL bounce_count: got %0d rises expected 1", rises);
    end
  endtask

  task automatic test_reset_mid_count();
    logic [2:0] exp;
    // From stable high: reset must clear the level at once, with no fall pulse.
    settle(1'b1, 12);
    i_rst = 1'b1;
    model_reset();
    #1;
    tests++;
    if (outs() !== 3'b000) begin
      fails++;
      $display("FAIL reset_from_high: got %b expected 000", outs());
    end
    tick();
    i_rst = 1'b0;
    settle(1'b0, 10);
    // Mid-count: reset after edge 5 of a press, held for 2 cycles.
    bus.i_btn = 1'b1;
    repeat (5) tick();
    i_rst = 1'b1;
    model_reset();
    #1;
    tests++;
    if (outs() !== 3'b000) begin
      fails++;
      $display("FAIL reset_mid_count: got %b expected 000", outs());
    end
    repeat (2) begin
      tick();
      tests++;
      if (outs() !== 3'b000) begin
        fails++;
        $display("FAIL reset_mid_hold: got %b expected 000", outs());
      end
    end
    i_rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp = {k >= 7, k == 7, 1'b0};
      tests++;
      if (outs() !== exp) begin
        fails++;
        $display("FAIL reset_mid_release edge %0d: got %b expected %b", k, outs(), exp);
      end
    end
  endtask

  task automatic test_random();
    int runs, len, m_rises, d_rises;
    m_rises = 0;
    d_rises = 0;
    for (runs = 0; runs < 400; runs++) begin
      bus.i_btn = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      repeat (len) begin
        tick();
        m_rises += m_rise;
        d_rises += bus.o_rise;
        tests++;
        if (outs() !== {m_lvl, m_rise, m_fall} || (bus.o_rise && bus.o_fall)) begin
          fails++;
          $display("FAIL random run %0d: got %b expected %b", runs, outs(), {m_lvl, m_rise, m_fall});
        end
      end
    end
    tests++;
    if (d_rises !== m_rises) begin
      fails++;
      $display("FAIL random_rise_count: got %0d expected %0d", d_rises, m_rises);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    i_rst = 1'b1;
    bus.i_btn = 1'b0;
    model_reset();
    test_reset();
    test_release();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_reset_mid_count();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
